// File: rtl/rv32i_types.sv
// Shared RV32I memory-interface types: bus widths, byte-mask type, arbiter owner encoding
// and the latched memory-request payload.
package rv32i_types;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WMASK_W = 4;

    typedef logic [WMASK_W-1:0] rv32i_mem_wmask;

    typedef enum logic [1:0] {
        own_none = 2'd0,
        own_i    = 2'd1,
        own_d    = 2'd2
    } arb_owner_t;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        rv32i_mem_wmask    wmask;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between instruction fetch and data access.
// Data wins by default; a pending fetch is forced through after MAX_D_STREAK data grants.
module mem_port_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_resp,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [WMASK_W-1:0]  d_wmask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_resp,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [ADDR_W-1:0]   pmem_addr,
    output logic [DATA_W-1:0]   pmem_wdata,
    output logic [WMASK_W-1:0]  pmem_wmask,
    input  logic [DATA_W-1:0]   pmem_rdata,
    input  logic                pmem_resp,
    output arb_owner_t          owner
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2
    } state_t;

    localparam int unsigned            STREAK_W   = 4;
    localparam logic [STREAK_W-1:0]    STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    state_t               state, state_next;
    logic [STREAK_W-1:0]  streak, streak_next;
    mem_req_t             req, req_next;
    arb_owner_t           owner_next;
    logic                 d_req;
    logic                 grant_d;
    logic                 grant_i;

    // State, streak, latched request and owner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            streak <= '0;
            req    <= '0;
            owner  <= own_none;
        end else begin
            state  <= state_next;
            streak <= streak_next;
            req    <= req_next;
            owner  <= owner_next;
        end
    end

    assign pmem_read  = req.read;
    assign pmem_write = req.write;
    assign pmem_addr  = req.addr;
    assign pmem_wdata = req.wdata;
    assign pmem_wmask = req.wmask;

    // Read data fans out to both sides; only the side pulsing resp consumes it
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // Arbitration, completion and streak bookkeeping
    always_comb begin
        state_next  = state;
        streak_next = streak;
        req_next    = req;
        owner_next  = own_none;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        d_req       = d_read | d_write;
        grant_d     = 1'b0;
        grant_i     = 1'b0;

        case (state)
            S_IDLE: begin
                grant_d = d_req && (!i_read || (streak < STREAK_MAX));
                grant_i = i_read && !grant_d;
                if (grant_d) begin
                    // Simultaneous read and write is serviced as a write
                    req_next.read  = !d_write;
                    req_next.write = d_write;
                    req_next.addr  = d_addr;
                    req_next.wdata = d_wdata;
                    req_next.wmask = d_wmask;
                    state_next     = S_BUSY_D;
                    if (!i_read) begin
                        streak_next = '0;
                    end else if (streak != STREAK_MAX) begin
                        streak_next = streak + STREAK_W'(1);
                    end
                end else if (grant_i) begin
                    req_next.read  = 1'b1;
                    req_next.write = 1'b0;
                    req_next.addr  = i_addr;
                    req_next.wdata = '0;
                    req_next.wmask = {WMASK_W{1'b1}};
                    state_next     = S_BUSY_I;
                    streak_next    = '0;
                end
            end
            S_BUSY_I: begin
                if (pmem_resp) begin
                    i_resp         = 1'b1;
                    req_next.read  = 1'b0;
                    req_next.write = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            S_BUSY_D: begin
                if (pmem_resp) begin
                    d_resp         = 1'b1;
                    req_next.read  = 1'b0;
                    req_next.write = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        case (state_next)
            S_BUSY_I: owner_next = own_i;
            S_BUSY_D: owner_next = own_d;
            default:  owner_next = own_none;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grants are queued when requests are
// driven and popped/compared as the physical port is strobed and completed.
module tb_mem_port_arbiter;
    import rv32i_types::*;

    logic               clk;
    logic               rst_n;
    logic               i_read;
    logic [31:0]        i_addr;
    logic [31:0]        i_rdata;
    logic               i_resp;
    logic               d_read;
    logic               d_write;
    logic [31:0]        d_addr;
    logic [31:0]        d_wdata;
    logic [3:0]         d_wmask;
    logic [31:0]        d_rdata;
    logic               d_resp;
    logic               pmem_read;
    logic               pmem_write;
    logic [31:0]        pmem_addr;
    logic [31:0]        pmem_wdata;
    logic [3:0]         pmem_wmask;
    logic [31:0]        pmem_rdata;
    logic               pmem_resp;
    arb_owner_t         owner;

    typedef struct packed {
        logic        side_d;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int   nvec;
    int   nerr;

    mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wmask    (d_wmask),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_wmask (pmem_wmask),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp),
        .owner      (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simultaneous data read and write is an illegal request encoding
    always @(negedge clk) begin
        if (rst_n && d_read && d_write) begin
            nerr++;
            $error("FAIL illegal_d_rw: observed d_read=1 d_write=1, expected at most one");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_i(input logic [31:0] addr, input logic [31:0] rdata);
        exp_t e;
        e.side_d = 1'b0; e.rd = 1'b1; e.wr = 1'b0;
        e.addr = addr; e.wdata = 32'h0; e.wmask = 4'hF; e.rdata = rdata;
        return e;
    endfunction

    function automatic exp_t mk_d(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] wmask, input logic [31:0] rdata);
        exp_t e;
        e.side_d = 1'b1; e.rd = !wr; e.wr = wr;
        e.addr = addr; e.wdata = wdata; e.wmask = wmask; e.rdata = rdata;
        return e;
    endfunction

    // Wait for the next grant, compare it with the scoreboard head, then complete it after lat idle cycles
    task automatic do_txn(input int lat);
        exp_t e;
        int   n;
        n = 0;
        tick();
        while (!(pmem_read || pmem_write) && n < 8) begin
            tick();
            n++;
        end
        chk("grant_latency", 32'(n), 32'd0);
        nvec++;
        assert (q.size() != 0) else begin
            nerr++;
            $error("FAIL scoreboard: observed empty queue, expected a pending grant");
        end
        if (q.size() == 0) return;
        e = q.pop_front();
        chk("grant_owner", 32'(owner), e.side_d ? 32'(own_d) : 32'(own_i));
        chk("grant_read", 32'(pmem_read), 32'(e.rd));
        chk("grant_write", 32'(pmem_write), 32'(e.wr));
        chk("grant_addr", pmem_addr, e.addr);
        chk("grant_wmask", 32'(pmem_wmask), 32'(e.wmask));
        if (e.wr) chk("grant_wdata", pmem_wdata, e.wdata);
        for (int k = 0; k < lat; k++) begin
            chk("hold_strobe", 32'({pmem_read, pmem_write}), 32'({e.rd, e.wr}));
            chk("hold_addr", pmem_addr, e.addr);
            chk("hold_resp", 32'({i_resp, d_resp}), 32'd0);
            tick();
        end
        pmem_rdata = e.rdata;
        pmem_resp  = 1'b1;
        #1;
        chk("resp_i", 32'(i_resp), 32'(!e.side_d));
        chk("resp_d", 32'(d_resp), 32'(e.side_d));
        chk("resp_rdata", e.side_d ? d_rdata : i_rdata, e.rdata);
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = $urandom;
        #1;
        chk("post_strobe", 32'({pmem_read, pmem_write}), 32'd0);
        chk("post_owner", 32'(owner), 32'(own_none));
        chk("post_resp", 32'({i_resp, d_resp}), 32'd0);
    endtask

    initial begin
        logic [31:0] ia;
        logic [31:0] da;
        exp_t        e;
        nvec = 0; nerr = 0;
        rst_n = 1'b0;
        i_read = 1'b0; i_addr = 32'h0;
        d_read = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wmask = 4'h0;
        pmem_rdata = 32'h0; pmem_resp = 1'b0;
        repeat (3) tick();
        chk("rst_read", 32'(pmem_read), 32'd0);
        chk("rst_write", 32'(pmem_write), 32'd0);
        chk("rst_addr", pmem_addr, 32'd0);
        chk("rst_wdata", pmem_wdata, 32'd0);
        chk("rst_wmask", 32'(pmem_wmask), 32'd0);
        chk("rst_owner", 32'(owner), 32'(own_none));
        chk("rst_resp", 32'({i_resp, d_resp}), 32'd0);
        rst_n = 1'b1;

        // Reset mid-operation: grant abandoned, fresh grant after release
        i_read = 1'b1; i_addr = 32'h60;
        tick();
        chk("mid_grant_read", 32'(pmem_read), 32'd1);
        chk("mid_grant_addr", pmem_addr, 32'h60);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_read", 32'(pmem_read), 32'd0);
        chk("mid_rst_owner", 32'(owner), 32'(own_none));
        pmem_resp = 1'b1;
        #1;
        chk("mid_rst_resp", 32'({i_resp, d_resp}), 32'd0);
        pmem_resp = 1'b0;
        tick();
        rst_n = 1'b1;
        q.push_back(mk_i(32'h60, 32'h1111_2222));
        do_txn(2);
        i_read = 1'b0;

        // Lone fetch: grant at cycle 1, resp at cycle 4
        i_read = 1'b1; i_addr = 32'h60;
        q.push_back(mk_i(32'h60, 32'h00A0_0093));
        do_txn(3);
        i_read = 1'b0;

        // Simultaneous fetch and store: data first, fetch next
        i_read = 1'b1; i_addr = 32'h64;
        d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
        q.push_back(mk_d(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 32'h0BAD_F00D));
        q.push_back(mk_i(32'h64, 32'h0000_0013));
        do_txn(1);
        d_write = 1'b0;
        do_txn(1);
        i_read = 1'b0;

        // Starvation bound: fetch held, data re-requested every arbitration
        ia = 32'h300; da = 32'h400;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin
                q.push_back(mk_i(ia, 32'hA000_0000 | 32'(k)));
                ia = ia + 32'd4;
            end else begin
                q.push_back(mk_d(1'b0, da, 32'h0, 4'h0, 32'hD000_0000 | 32'(k)));
                da = da + 32'd4;
            end
        end
        i_read = 1'b1; i_addr = 32'h300;
        d_read = 1'b1; d_addr = 32'h400; d_wmask = 4'h0; d_wdata = 32'h0;
        for (int k = 0; k < 10; k++) begin
            e = (q.size() != 0) ? q[0] : '0;
            do_txn(1);
            if (e.side_d) d_addr = d_addr + 32'd4;
            else          i_addr = i_addr + 32'd4;
        end
        i_read = 1'b0; d_read = 1'b0;

        // Store with long memory latency
        d_write = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678; d_wmask = 4'hC;
        q.push_back(mk_d(1'b1, 32'h200, 32'h1234_5678, 4'hC, 32'h5555_AAAA));
        do_txn(7);
        d_write = 1'b0;

        // Spurious pmem_resp while idle
        tick();
        pmem_resp = 1'b1; pmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("spur_resp", 32'({i_resp, d_resp}), 32'd0);
        tick();
        pmem_resp = 1'b0;
        chk("spur_owner", 32'(owner), 32'(own_none));
        chk("spur_strobe", 32'({pmem_read, pmem_write}), 32'd0);
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
